ifetch_unit: RTL
================

# ifetch_unit

Instruction-fetch and next-PC stage of the multi-cycle MIPS datapath. Holds the PC, fetches one word at a time from instruction memory over a req/ack handshake, and presents the fetched instruction plus its `Imm16` field to decode and the immediate extender. It consumes the extender's 32-bit output and the decode control to compute the sequential, branch, jump or jr next PC.

## Interface
- `RESET_PC`, 32'h0000_3000, address of the first fetch after reset.
- `clk`  in  1  system clock, rising edge.
- `rstn`  in  1  synchronous reset, active low.
- `stall`  in  1  decode cannot accept the instruction; hold IR.
- `redirect`  in  1  decode has resolved a control transfer for the instruction in IR (valid only with `ir_valid`).
- `NPCOp`  in  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jr.
- `Imm32`  in  32  extended immediate from the extender (sign-extended for branches).
- `JIdx`  in  26  jump index, IR[25:0] as decoded.
- `RD`  in  32  register value for jr.
- `im_req`  out  1  instruction-memory read request.
- `im_addr`  out  32  read address.
- `im_ack`  in  1  memory returns data this cycle.
- `im_rdata`  in  32  read data, valid with `im_ack`.
- `IR`  out  32  current instruction.
- `ir_valid`  out  1  IR holds an unconsumed instruction.
- `PC`  out  32  address of the instruction in IR.
- `PCPLUS4`  out  32  PC + 4, combinational.
- `Imm16`  out  16  IR[15:0], combinational, feeds the extender.
- `addr_err`  out  1  sticky: misaligned jr target seen.

## Operation
- States: FETCH, HAVE.
- Reset (`rstn`=0 at a rising edge): state FETCH, `fetch_pc`=RESET_PC, `IR`=0, `PC`=RESET_PC, `ir_valid`=0, `addr_err`=0. Reset is honoured mid-handshake; an `im_ack` in the reset cycle is discarded.
- FETCH: `im_req`=1, `im_addr`=`fetch_pc`, stable until ack. On `im_ack`: `IR`<=`im_rdata`, `PC`<=`fetch_pc`, `ir_valid`<=1, go to HAVE.
- HAVE: `im_req`=0. If `stall`=1, everything holds. If `stall`=0, the instruction is consumed: `ir_valid`<=0, `fetch_pc`<=next, go to FETCH.
- next, selected only when `redirect`=1, else PC+4:
  - 00: PC+4.
  - 01: PC+4 + (Imm32 << 2), low 32 bits.
  - 10: {PCPLUS4[31:28], JIdx, 2'b00}.
  - 11: {RD[31:2], 2'b00}. If RD[1:0]≠0, `addr_err`<=1, held until reset.
- There is no delay slot. The branch/jump target is the very next fetch.
- All adds are modulo 2^32: PC 32'hFFFF_FFFC gives next 32'h0000_0000.
- `redirect` and `NPCOp` are ignored in FETCH, or when `stall`=1.

## Timing
- Minimum of 2 cycles per instruction: FETCH with `im_ack` in the same cycle, then HAVE with `stall`=0.
- Each memory wait cycle adds one cycle. Each stall cycle adds one cycle.
- `IR`, `PC`, `ir_valid` and `addr_err` are registered. `im_req`, `im_addr`, `PCPLUS4` and `Imm16` are combinational from registered state.
- `im_addr` of the first fetch equals RESET_PC in the first cycle after `rstn` is released.
- A redirect in HAVE affects `im_addr` in the next cycle (FETCH).

## Test plan
- Reset then zero-wait memory returning 32'h2008_0005 at 0x3000, `stall`=0, no redirect.
  - `im_addr` sequence: 0x3000, then 0x3004.
  - `IR`=32'h2008_0005 and `PC`=0x3000 in the cycle after ack.
  - `Imm16`=16'h0005.
- Ack delayed 3 cycles.
  - `im_req` and `im_addr` held constant for 3 cycles.
  - `ir_valid` rises exactly one cycle after the ack.
- Branch at PC 0x3010, Imm32=32'hFFFF_FFFF, `redirect`=1, `NPCOp`=01 → next `im_addr`=0x3010 (self-loop).
- Branch at PC 0x3010, Imm32=32'h0000_0004 → next `im_addr`=0x3024.
- Jump at PC 0x3020, JIdx=26'h000_0C40 → next `im_addr`=0x0000_3100.
- jr with RD=32'h0000_3006 → next `im_addr`=0x3004 and `addr_err`=1.
  - `addr_err` stays 1 through later fetches until reset.
- `stall` high for 4 cycles in HAVE while `redirect`=1:
  - `IR` and `PC` are held, and no fetch is issued.
  - When `stall` drops, the redirect target is fetched.
- `rstn` low during a pending FETCH with `im_ack`=1 in that cycle:
  - `ir_valid`=0 and `IR`=0.
  - After release, `im_addr`=RESET_PC.
- PC wrap: the instruction is fetched at 32'hFFFF_FFFC, then released with no redirect → next `im_addr`=0x0000_0000.

Source files
------------

// File: rtl/ifetch_unit.sv
// Purpose : instruction fetch and next-PC stage; holds PC, reads instruction memory, forms seq/branch/jump/jr next PC.
// Latency : at least 2 cycles per instruction (FETCH with same-cycle ack, then HAVE); each memory wait or stall adds 1.
// Backpr. : im_req/im_addr held until im_ack; stall in HAVE freezes IR/PC and blocks the next fetch.
//
// Ports:
//   clk, rstn              clock, synchronous active-low reset
//   stall, redirect        decode handshake / control-transfer resolved for IR
//   NPCOp, Imm32, JIdx, RD next-PC select and operands (00 seq, 01 branch, 10 jump, 11 jr)
//   im_req, im_addr        instruction-memory read request and address
//   im_ack, im_rdata       memory response
//   IR, ir_valid, PC       fetched instruction, its valid flag and address
//   PCPLUS4, Imm16         PC+4 and IR[15:0] for decode / extender
//   addr_err               sticky misaligned-jr flag
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        redirect,
  input  logic [1:0]  NPCOp,
  input  logic [31:0] Imm32,
  input  logic [25:0] JIdx,
  input  logic [31:0] RD,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] IR,
  output logic        ir_valid,
  output logic [31:0] PC,
  output logic [31:0] PCPLUS4,
  output logic [15:0] Imm16,
  output logic        addr_err
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] HAVE  = 1'b1;

  logic [0:0]  state_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] ir_q;
  logic [31:0] pc_q;
  logic        ir_valid_q;
  logic        addr_err_q;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc_d;
  logic        consume;
  logic        jr_misaligned;

  assign pc_plus4 = pc_q + 32'd4;
  assign consume  = (state_q == HAVE) && !stall;

  // Misalignment only matters when the jr is actually taken.
  assign jr_misaligned = redirect && (NPCOp == 2'b11) && (RD[1:0] != 2'b00);

  // Next fetch address for the instruction in IR; no delay slot, so the
  // target is fetched directly.
  always_comb begin
    next_pc_d = pc_plus4;
    if (redirect) begin
      case (NPCOp)
        2'b01:   next_pc_d = pc_plus4 + (Imm32 << 2);
        2'b10:   next_pc_d = {pc_plus4[31:28], JIdx, 2'b00};
        2'b11:   next_pc_d = {RD[31:2], 2'b00};
        default: next_pc_d = pc_plus4;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      // Takes priority over a same-cycle im_ack, which is dropped.
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      ir_q       <= 32'd0;
      pc_q       <= RESET_PC;
      ir_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else if (state_q == FETCH) begin
      if (im_ack) begin
        ir_q       <= im_rdata;
        pc_q       <= fetch_pc_q;
        ir_valid_q <= 1'b1;
        state_q    <= HAVE;
      end
    end else begin
      if (consume) begin
        ir_valid_q <= 1'b0;
        fetch_pc_q <= next_pc_d;
        state_q    <= FETCH;
        if (jr_misaligned) begin
          addr_err_q <= 1'b1;
        end
      end
    end
  end

  assign im_req   = (state_q == FETCH);
  assign im_addr  = fetch_pc_q;
  assign IR       = ir_q;
  assign ir_valid = ir_valid_q;
  assign PC       = pc_q;
  assign PCPLUS4  = pc_plus4;
  assign Imm16    = ir_q[15:0];
  assign addr_err = addr_err_q;

endmodule
